// File: rtl/axi_mem_tester_pkg.sv
// Shared types, AXI field constants and the test data pattern for the
// AXI4 memory tester.
package axi_mem_tester_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WR_AW = 3'd1,
      ST_WR_W  = 3'd2,
      ST_WR_B  = 3'd3,
      ST_RD_AR = 3'd4,
      ST_RD_R  = 3'd5,
      ST_FIN   = 3'd6
   } state_e;

   localparam logic [1:0] BURST_INCR    = 2'b01;
   localparam logic [2:0] SIZE_8B       = 3'b011;
   localparam logic [1:0] RESP_OKAY     = 2'b00;
   localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

   // Data written to / expected from beat address addr.
   function automatic logic [63:0] pattern(input logic [31:0] addr);
      return {~addr, addr};
   endfunction

endpackage

// File: rtl/axi_mem_tester_if.sv
// AXI4 bus bundle (64-bit data, 4-bit ID) between the tester and memory.
interface axi_mem_tester_if;
   logic        aw_valid;
   logic        aw_ready;
   logic [3:0]  aw_id;
   logic [31:0] aw_addr;
   logic [7:0]  aw_len;
   logic [2:0]  aw_size;
   logic [1:0]  aw_burst;
   logic        aw_lock;
   logic [3:0]  aw_cache;
   logic [2:0]  aw_prot;
   logic [3:0]  aw_qos;

   logic        w_valid;
   logic        w_ready;
   logic [63:0] w_data;
   logic [7:0]  w_strb;
   logic        w_last;

   logic        b_valid;
   logic        b_ready;
   logic [3:0]  b_id;
   logic [1:0]  b_resp;

   logic        ar_valid;
   logic        ar_ready;
   logic [3:0]  ar_id;
   logic [31:0] ar_addr;
   logic [7:0]  ar_len;
   logic [2:0]  ar_size;
   logic [1:0]  ar_burst;
   logic        ar_lock;
   logic [3:0]  ar_cache;
   logic [2:0]  ar_prot;
   logic [3:0]  ar_qos;

   logic        r_valid;
   logic        r_ready;
   logic [3:0]  r_id;
   logic [63:0] r_data;
   logic [1:0]  r_resp;
   logic        r_last;

   modport master (
      output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
             aw_lock, aw_cache, aw_prot, aw_qos,
      input  aw_ready,
      output w_valid, w_data, w_strb, w_last,
      input  w_ready,
      input  b_valid, b_id, b_resp,
      output b_ready,
      output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
             ar_lock, ar_cache, ar_prot, ar_qos,
      input  ar_ready,
      input  r_valid, r_id, r_data, r_resp, r_last,
      output r_ready
   );

   modport slave (
      input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
             aw_lock, aw_cache, aw_prot, aw_qos,
      output aw_ready,
      input  w_valid, w_data, w_strb, w_last,
      output w_ready,
      output b_valid, b_id, b_resp,
      input  b_ready,
      input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
             ar_lock, ar_cache, ar_prot, ar_qos,
      output ar_ready,
      output r_valid, r_id, r_data, r_resp, r_last,
      input  r_ready
   );
endinterface

// File: rtl/axi_beat_counter.sv
// Beat/burst position and address generator shared by the write and read
// phases. Addresses are kept in registers so AW/AR/W payloads come straight
// from flops and stay stable while a handshake is stalled.
module axi_beat_counter #(
   parameter int unsigned BURST_LEN = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] base_addr,
   input  logic [15:0] num_bursts,
   input  logic        restart,
   input  logic        burst_inc,
   input  logic        beat_inc,
   output logic [31:0] burst_addr,
   output logic [31:0] beat_addr,
   output logic        beat_last,
   output logic        burst_last
);

   localparam int unsigned BURST_BYTES = BURST_LEN * 8;
   localparam logic [31:0] ALIGN_MASK  = ~(32'(BURST_BYTES) - 32'd1);
   localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);

   logic [31:0] base_q, base_d;
   logic [15:0] num_q, num_d;
   logic [15:0] burst_q, burst_d;
   logic [7:0]  beat_q, beat_d;
   logic [31:0] burst_addr_q, burst_addr_d;
   logic [31:0] beat_addr_q, beat_addr_d;

   // Next position: load a new region, rewind for the read pass, or step.
   always_comb begin
      base_d       = base_q;
      num_d        = num_q;
      burst_d      = burst_q;
      beat_d       = beat_q;
      burst_addr_d = burst_addr_q;
      beat_addr_d  = beat_addr_q;
      if (load) begin
         base_d       = base_addr & ALIGN_MASK;
         num_d        = num_bursts;
         burst_d      = '0;
         beat_d       = '0;
         burst_addr_d = base_addr & ALIGN_MASK;
         beat_addr_d  = base_addr & ALIGN_MASK;
      end else if (restart) begin
         burst_d      = '0;
         beat_d       = '0;
         burst_addr_d = base_q;
         beat_addr_d  = base_q;
      end else if (burst_inc) begin
         burst_d      = burst_q + 16'd1;
         beat_d       = '0;
         burst_addr_d = burst_addr_q + 32'(BURST_BYTES);
         beat_addr_d  = burst_addr_q + 32'(BURST_BYTES);
      end else if (beat_inc) begin
         beat_d      = beat_q + 8'd1;
         beat_addr_d = beat_addr_q + 32'd8;
      end
   end

   // Position registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         base_q       <= '0;
         num_q        <= '0;
         burst_q      <= '0;
         beat_q       <= '0;
         burst_addr_q <= '0;
         beat_addr_q  <= '0;
      end else begin
         base_q       <= base_d;
         num_q        <= num_d;
         burst_q      <= burst_d;
         beat_q       <= beat_d;
         burst_addr_q <= burst_addr_d;
         beat_addr_q  <= beat_addr_d;
      end
   end

   assign burst_addr = burst_addr_q;
   assign beat_addr  = beat_addr_q;
   assign beat_last  = (beat_q == LAST_BEAT);
   assign burst_last = (burst_q == (num_q - 16'd1));

endmodule

// File: rtl/axi_mem_tester.sv
// AXI4 memory tester: writes {~A, A} over a region in fixed INCR bursts,
// reads it back and reports pass, error count and first failing address.
// One transaction outstanding at a time.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_WR_AW | write address offered, waiting for aw_ready
//   ST_WR_W  | streaming write beats
//   ST_WR_B  | waiting for the write response
//   ST_RD_AR | read address offered, waiting for ar_ready
//   ST_RD_R  | receiving and checking read beats
//   ST_FIN   | issue done pulse and final pass verdict
module axi_mem_tester
   import axi_mem_tester_pkg::*;
#(
   parameter int unsigned BURST_LEN = 16,
   parameter logic [3:0]  ID        = 4'd0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [31:0]             base_addr,
   input  logic [15:0]             num_bursts,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic [15:0]             err_count,
   output logic [31:0]             first_err_addr,
   axi_mem_tester_if.master        io_axi4
);

   state_e      state_q, state_d;
   logic        aw_valid_q, aw_valid_d;
   logic        w_valid_q, w_valid_d;
   logic        b_ready_q, b_ready_d;
   logic        ar_valid_q, ar_valid_d;
   logic        r_ready_q, r_ready_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic [15:0] err_count_q, err_count_d;
   logic [31:0] first_err_q, first_err_d;

   logic        cnt_load, cnt_restart, cnt_burst_inc, cnt_beat_inc;
   logic [31:0] cnt_burst_addr, cnt_beat_addr;
   logic        cnt_beat_last, cnt_burst_last;
   logic        err_hit;
   logic [31:0] err_addr;

   axi_beat_counter #(.BURST_LEN(BURST_LEN)) u_cnt (
      .clock      (clock),
      .reset      (reset),
      .load       (cnt_load),
      .base_addr  (base_addr),
      .num_bursts (num_bursts),
      .restart    (cnt_restart),
      .burst_inc  (cnt_burst_inc),
      .beat_inc   (cnt_beat_inc),
      .burst_addr (cnt_burst_addr),
      .beat_addr  (cnt_beat_addr),
      .beat_last  (cnt_beat_last),
      .burst_last (cnt_burst_last)
   );

   // Sequencer: next state, next registered handshake outputs, error logging.
   always_comb begin
      state_d       = state_q;
      aw_valid_d    = aw_valid_q;
      w_valid_d     = w_valid_q;
      b_ready_d     = b_ready_q;
      ar_valid_d    = ar_valid_q;
      r_ready_d     = r_ready_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      pass_d        = pass_q;
      err_count_d   = err_count_q;
      first_err_d   = first_err_q;
      cnt_load      = 1'b0;
      cnt_restart   = 1'b0;
      cnt_burst_inc = 1'b0;
      cnt_beat_inc  = 1'b0;
      err_hit       = 1'b0;
      err_addr      = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               busy_d      = 1'b1;
               pass_d      = 1'b0;
               err_count_d = '0;
               first_err_d = '0;
               if (num_bursts == 16'd0) begin
                  state_d = ST_FIN;
               end else begin
                  cnt_load   = 1'b1;
                  aw_valid_d = 1'b1;
                  state_d    = ST_WR_AW;
               end
            end
         end
         ST_WR_AW: begin
            if (io_axi4.aw_ready) begin
               aw_valid_d = 1'b0;
               w_valid_d  = 1'b1;
               state_d    = ST_WR_W;
            end
         end
         ST_WR_W: begin
            if (io_axi4.w_ready) begin
               if (cnt_beat_last) begin
                  w_valid_d = 1'b0;
                  b_ready_d = 1'b1;
                  state_d   = ST_WR_B;
               end else begin
                  cnt_beat_inc = 1'b1;
               end
            end
         end
         ST_WR_B: begin
            if (io_axi4.b_valid) begin
               b_ready_d = 1'b0;
               err_hit   = (io_axi4.b_resp != RESP_OKAY) || (io_axi4.b_id != ID);
               err_addr  = cnt_burst_addr;
               if (cnt_burst_last) begin
                  cnt_restart = 1'b1;
                  ar_valid_d  = 1'b1;
                  state_d     = ST_RD_AR;
               end else begin
                  cnt_burst_inc = 1'b1;
                  aw_valid_d    = 1'b1;
                  state_d       = ST_WR_AW;
               end
            end
         end
         ST_RD_AR: begin
            if (io_axi4.ar_ready) begin
               ar_valid_d = 1'b0;
               r_ready_d  = 1'b1;
               state_d    = ST_RD_R;
            end
         end
         ST_RD_R: begin
            if (io_axi4.r_valid) begin
               // A misplaced r_last folds into the same single per-beat error.
               err_hit  = (io_axi4.r_resp != RESP_OKAY) || (io_axi4.r_id != ID) ||
                          (io_axi4.r_data != pattern(cnt_beat_addr)) ||
                          (io_axi4.r_last != cnt_beat_last);
               err_addr = cnt_beat_addr;
               if (io_axi4.r_last || cnt_beat_last) begin
                  r_ready_d = 1'b0;
                  if (cnt_burst_last) begin
                     state_d = ST_FIN;
                  end else begin
                     cnt_burst_inc = 1'b1;
                     ar_valid_d    = 1'b1;
                     state_d       = ST_RD_AR;
                  end
               end else begin
                  cnt_beat_inc = 1'b1;
               end
            end
         end
         ST_FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_count_q == 16'd0);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (err_hit) begin
         if (err_count_q == 16'd0) first_err_d = err_addr;
         if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         aw_valid_q  <= 1'b0;
         w_valid_q   <= 1'b0;
         b_ready_q   <= 1'b0;
         ar_valid_q  <= 1'b0;
         r_ready_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_count_q <= '0;
         first_err_q <= '0;
      end else begin
         state_q     <= state_d;
         aw_valid_q  <= aw_valid_d;
         w_valid_q   <= w_valid_d;
         b_ready_q   <= b_ready_d;
         ar_valid_q  <= ar_valid_d;
         r_ready_q   <= r_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_count_q <= err_count_d;
         first_err_q <= first_err_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_count_q;
   assign first_err_addr = first_err_q;

   assign io_axi4.aw_valid = aw_valid_q;
   assign io_axi4.aw_id    = ID;
   assign io_axi4.aw_addr  = cnt_burst_addr;
   assign io_axi4.aw_len   = 8'(BURST_LEN - 1);
   assign io_axi4.aw_size  = SIZE_8B;
   assign io_axi4.aw_burst = BURST_INCR;
   assign io_axi4.aw_lock  = 1'b0;
   assign io_axi4.aw_cache = CACHE_DEFAULT;
   assign io_axi4.aw_prot  = 3'b000;
   assign io_axi4.aw_qos   = 4'b0000;

   assign io_axi4.w_valid = w_valid_q;
   assign io_axi4.w_data  = pattern(cnt_beat_addr);
   assign io_axi4.w_strb  = 8'hFF;
   assign io_axi4.w_last  = cnt_beat_last;

   assign io_axi4.b_ready = b_ready_q;

   assign io_axi4.ar_valid = ar_valid_q;
   assign io_axi4.ar_id    = ID;
   assign io_axi4.ar_addr  = cnt_burst_addr;
   assign io_axi4.ar_len   = 8'(BURST_LEN - 1);
   assign io_axi4.ar_size  = SIZE_8B;
   assign io_axi4.ar_burst = BURST_INCR;
   assign io_axi4.ar_lock  = 1'b0;
   assign io_axi4.ar_cache = CACHE_DEFAULT;
   assign io_axi4.ar_prot  = 3'b000;
   assign io_axi4.ar_qos   = 4'b0000;

   assign io_axi4.r_ready = r_ready_q;

endmodule

// File: tb/tb_axi_mem_tester.sv
// Bench for axi_mem_tester: a reactive AXI memory slave with optional random
// stalls and fault injection, plus a region-level model of expected results.
`timescale 1ns/1ps
module tb_axi_mem_tester;

   localparam int         BL  = 16;
   localparam logic [3:0] TID = 4'd0;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
   } rbeat_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic [15:0] num_bursts = '0;
   logic        busy, done, pass;
   logic [15:0] err_count;
   logic [31:0] first_err_addr;

   axi_mem_tester_if io_axi4 ();

   axi_mem_tester #(.BURST_LEN(BL), .ID(TID)) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .base_addr      (base_addr),
      .num_bursts     (num_bursts),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .io_axi4        (io_axi4)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // scenario knobs
   bit bp_en = 1'b0;
   int corrupt_burst = -1;
   int corrupt_beat  = -1;
   int bresp_err_burst = -1;

   // slave state and traffic records
   logic [63:0] mem [logic [31:0]];
   logic [31:0] aw_rec[$];
   logic [31:0] ar_rec[$];
   logic [63:0] w_rec[$];
   logic [1:0]  bq[$];
   rbeat_t      rq[$];
   int          aw_gap, w_gap, ar_gap, b_gap, r_gap;
   bit          b_hs, r_hs;
   bit          aw_stall, w_stall, ar_stall;
   logic [31:0] aw_hold, ar_hold;
   logic [64:0] w_hold;
   logic [31:0] wr_addr;
   int          wr_beat, wr_burst_idx, rd_burst_idx;
   bit          any_valid;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] beat_addr(input logic [31:0] base, input int b, input int i);
      return (base & ~32'(BL * 8 - 1)) + 32'(b * BL * 8) + 32'(i * 8);
   endfunction

   // Expected error list: write-response errors during the write pass, then
   // corrupted read beats in address order during the read pass.
   task automatic model(input logic [31:0] base, input int n, output int cnt, output logic [31:0] first);
      logic [31:0] errs[$];
      for (int b = 0; b < n; b++)
         if (b == bresp_err_burst) errs.push_back(beat_addr(base, b, 0));
      for (int b = 0; b < n; b++)
         for (int i = 0; i < BL; i++)
            if (b == corrupt_burst && i == corrupt_beat) errs.push_back(beat_addr(base, b, i));
      cnt   = errs.size();
      first = (cnt > 0) ? errs[0] : 32'd0;
   endtask

   task automatic slave_clear();
      io_axi4.aw_ready = 1'b0;
      io_axi4.w_ready  = 1'b0;
      io_axi4.ar_ready = 1'b0;
      io_axi4.b_valid  = 1'b0;
      io_axi4.b_id     = TID;
      io_axi4.b_resp   = 2'b00;
      io_axi4.r_valid  = 1'b0;
      io_axi4.r_id     = TID;
      io_axi4.r_data   = '0;
      io_axi4.r_resp   = 2'b00;
      io_axi4.r_last   = 1'b0;
      bq.delete();
      rq.delete();
      {aw_gap, w_gap, ar_gap, b_gap, r_gap} = '0;
      {b_hs, r_hs, aw_stall, w_stall, ar_stall} = '0;
      wr_beat = 0;
      wr_addr = '0;
   endtask

   // Memory slave: decides this half-cycle's drive at each falling edge; a
   // handshake completes at the following rising edge.
   initial begin
      slave_clear();
      forever begin
         @(negedge clock);
         if (reset) begin
            slave_clear();
            continue;
         end
         any_valid = any_valid | io_axi4.aw_valid | io_axi4.w_valid | io_axi4.ar_valid;

         if (aw_stall) check("aw_stable", {io_axi4.aw_valid, io_axi4.aw_addr}, {1'b1, aw_hold});
         if (w_stall)  check("w_stable", {io_axi4.w_valid, io_axi4.w_last, io_axi4.w_data}, {1'b1, w_hold});
         if (ar_stall) check("ar_stable", {io_axi4.ar_valid, io_axi4.ar_addr}, {1'b1, ar_hold});

         // B channel
         if (b_hs) begin
            bq.delete(0);
            io_axi4.b_valid = 1'b0;
            b_gap = bp_en ? int'($urandom_range(0, 7)) : 0;
            b_hs = 1'b0;
         end
         if (!io_axi4.b_valid && bq.size() > 0) begin
            if (b_gap > 0) b_gap--;
            else begin
               io_axi4.b_valid = 1'b1;
               io_axi4.b_resp  = bq[0];
               io_axi4.b_id    = TID;
            end
         end
         b_hs = io_axi4.b_valid && io_axi4.b_ready;

         // R channel
         if (r_hs) begin
            rq.delete(0);
            io_axi4.r_valid = 1'b0;
            r_gap = bp_en ? int'($urandom_range(0, 7)) : 0;
            r_hs = 1'b0;
         end
         if (!io_axi4.r_valid && rq.size() > 0) begin
            if (r_gap > 0) r_gap--;
            else begin
               io_axi4.r_valid = 1'b1;
               io_axi4.r_data  = rq[0].data;
               io_axi4.r_last  = rq[0].last;
               io_axi4.r_resp  = 2'b00;
               io_axi4.r_id    = TID;
            end
         end
         r_hs = io_axi4.r_valid && io_axi4.r_ready;

         // AW channel
         if (io_axi4.aw_valid) begin
            if (aw_gap > 0) begin io_axi4.aw_ready = 1'b0; aw_gap--; end
            else io_axi4.aw_ready = 1'b1;
         end else io_axi4.aw_ready = !bp_en;
         if (io_axi4.aw_valid && io_axi4.aw_ready) begin
            aw_rec.push_back(io_axi4.aw_addr);
            wr_addr = io_axi4.aw_addr;
            wr_beat = 0;
            check("aw_len", io_axi4.aw_len, 8'(BL - 1));
            check("aw_fixed", {io_axi4.aw_id, io_axi4.aw_size, io_axi4.aw_burst, io_axi4.aw_lock,
                               io_axi4.aw_cache, io_axi4.aw_prot, io_axi4.aw_qos},
                  {TID, 3'b011, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000});
            aw_gap = bp_en ? int'($urandom_range(0, 7)) : 0;
         end
         aw_stall = io_axi4.aw_valid && !io_axi4.aw_ready;
         aw_hold  = io_axi4.aw_addr;

         // W channel
         if (io_axi4.w_valid) begin
            if (w_gap > 0) begin io_axi4.w_ready = 1'b0; w_gap--; end
            else io_axi4.w_ready = 1'b1;
         end else io_axi4.w_ready = !bp_en;
         if (io_axi4.w_valid && io_axi4.w_ready) begin
            w_rec.push_back(io_axi4.w_data);
            mem[wr_addr + 32'(wr_beat * 8)] = io_axi4.w_data;
            check("w_last", io_axi4.w_last, (wr_beat == BL - 1));
            check("w_strb", io_axi4.w_strb, 8'hFF);
            if (wr_beat == BL - 1) begin
               bq.push_back((wr_burst_idx == bresp_err_burst) ? 2'b10 : 2'b00);
               wr_burst_idx++;
            end
            wr_beat++;
            w_gap = bp_en ? int'($urandom_range(0, 7)) : 0;
         end
         w_stall = io_axi4.w_valid && !io_axi4.w_ready;
         w_hold  = {io_axi4.w_last, io_axi4.w_data};

         // AR channel
         if (io_axi4.ar_valid) begin
            if (ar_gap > 0) begin io_axi4.ar_ready = 1'b0; ar_gap--; end
            else io_axi4.ar_ready = 1'b1;
         end else io_axi4.ar_ready = !bp_en;
         if (io_axi4.ar_valid && io_axi4.ar_ready) begin
            ar_rec.push_back(io_axi4.ar_addr);
            check("ar_len", io_axi4.ar_len, 8'(BL - 1));
            check("ar_fixed", {io_axi4.ar_id, io_axi4.ar_size, io_axi4.ar_burst, io_axi4.ar_lock,
                               io_axi4.ar_cache, io_axi4.ar_prot, io_axi4.ar_qos},
                  {TID, 3'b011, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000});
            for (int i = 0; i < BL; i++) begin
               rbeat_t      rb;
               logic [31:0] a;
               a = io_axi4.ar_addr + 32'(i * 8);
               rb.data = mem.exists(a) ? mem[a] : 64'h0;
               if (rd_burst_idx == corrupt_burst && i == corrupt_beat) rb.data[0] = ~rb.data[0];
               rb.last = (i == BL - 1);
               rq.push_back(rb);
            end
            rd_burst_idx++;
            ar_gap = bp_en ? int'($urandom_range(0, 7)) : 0;
         end
         ar_stall = io_axi4.ar_valid && !io_axi4.ar_ready;
         ar_hold  = io_axi4.ar_addr;
      end
   end

   task automatic run_test(input string tag, input logic [31:0] base, input int n);
      int          exp_cnt;
      logic [31:0] exp_first;
      bit          seen;
      aw_rec.delete();
      ar_rec.delete();
      w_rec.delete();
      wr_burst_idx = 0;
      rd_burst_idx = 0;
      model(base, n, exp_cnt, exp_first);
      @(posedge clock); #1;
      base_addr  = base;
      num_bursts = 16'(n);
      start      = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check({tag, "_busy_rise"}, busy, 1'b1);
      check({tag, "_aw_valid_rise"}, io_axi4.aw_valid, 1'b1);
      seen = 1'b0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         if (done) begin seen = 1'b1; break; end
         @(posedge clock); #1;
      end
      check({tag, "_done_seen"}, seen, 1'b1);
      check({tag, "_busy_at_done"}, busy, 1'b0);
      check({tag, "_pass"}, pass, (exp_cnt == 0));
      check({tag, "_err_count"}, err_count, 16'(exp_cnt));
      check({tag, "_first_err_addr"}, first_err_addr, exp_first);
      @(posedge clock); #1;
      check({tag, "_done_pulse"}, done, 1'b0);
      check({tag, "_pass_held"}, pass, (exp_cnt == 0));
      check({tag, "_aw_count"}, aw_rec.size(), n);
      check({tag, "_ar_count"}, ar_rec.size(), n);
      check({tag, "_w_count"}, w_rec.size(), n * BL);
      for (int b = 0; b < n && b < aw_rec.size(); b++)
         check({tag, "_aw_addr"}, aw_rec[b], beat_addr(base, b, 0));
      for (int b = 0; b < n && b < ar_rec.size(); b++)
         check({tag, "_ar_addr"}, ar_rec[b], beat_addr(base, b, 0));
      for (int k = 0; k < w_rec.size() && k < n * BL; k++) begin
         logic [31:0] a;
         a = beat_addr(base, k / BL, k % BL);
         check({tag, "_w_data"}, w_rec[k], {~a, a});
      end
   endtask

   initial begin
      logic [31:0] rbase;
      int          rn;
      bit          seen;

      // reset values
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_valids", {io_axi4.aw_valid, io_axi4.w_valid, io_axi4.ar_valid,
                           io_axi4.b_ready, io_axi4.r_ready}, 5'b0);
      check("rst_status", {busy, done, pass}, 3'b0);
      check("rst_err_count", err_count, 16'h0);
      check("rst_first_err", first_err_addr, 32'h0);
      reset = 1'b0;

      // back-to-back, always-ready memory
      run_test("b2b", 32'h0000_1000, 2);
      if (w_rec.size() > 0) check("b2b_first_beat", w_rec[0], 64'hFFFF_EFFF_0000_1000);
      if (aw_rec.size() > 1) check("b2b_aw1", aw_rec[1], 32'h0000_1080);

      // corrupted read beat 5 of burst 1
      corrupt_burst = 1;
      corrupt_beat  = 5;
      run_test("corrupt", 32'h0000_1000, 2);
      check("corrupt_first_const", first_err_addr, 32'h0000_10A8);
      corrupt_burst = -1;
      corrupt_beat  = -1;

      // random stalls on every channel
      bp_en = 1'b1;
      run_test("bp", 32'h0000_1000, 2);
      bp_en = 1'b0;

      // SLVERR on burst 0
      bresp_err_burst = 0;
      run_test("bresp", 32'h0000_1000, 2);
      bresp_err_burst = -1;

      // randomized region, faults and stalls
      for (int t = 0; t < 3; t++) begin
         bp_en = 1'b1;
         rbase = $urandom;
         rn = int'($urandom_range(1, 4));
         corrupt_burst   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, rn - 1)) : -1;
         corrupt_beat    = int'($urandom_range(0, BL - 1));
         bresp_err_burst = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, rn - 1)) : -1;
         run_test("rand", rbase, rn);
      end
      bp_en = 1'b0;
      corrupt_burst   = -1;
      corrupt_beat    = -1;
      bresp_err_burst = -1;

      // empty test: done two cycles after start, no traffic
      any_valid = 1'b0;
      @(posedge clock); #1;
      num_bursts = 16'd0;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check("empty_busy", {busy, done}, 2'b10);
      @(posedge clock); #1;
      check("empty_done", {busy, done, pass}, 3'b011);
      check("empty_err_count", err_count, 16'h0);
      repeat (3) @(posedge clock);
      #1;
      check("empty_no_valid", any_valid, 1'b0);

      // reset in the middle of the write data phase
      @(posedge clock); #1;
      base_addr  = 32'h0000_2000;
      num_bursts = 16'd2;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      seen = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (io_axi4.w_valid) begin seen = 1'b1; break; end
         @(posedge clock); #1;
      end
      check("rr_reached_w", seen, 1'b1);
      @(posedge clock); #2;
      reset = 1'b1;
      #1;
      check("rr_async_valids", {io_axi4.aw_valid, io_axi4.w_valid, io_axi4.ar_valid,
                                io_axi4.b_ready, io_axi4.r_ready}, 5'b0);
      check("rr_async_busy", {busy, done, pass}, 3'b0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      run_test("rr_after", 32'h0000_3000, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_mem_tester.md
Name: axi_mem_tester

Overview:
- AXI4 master (initiator) that exercises the DDR-backed AXI4 memory slave port.
- Writes a deterministic address-derived pattern over a region in fixed-length INCR bursts, reads the region back, compares, and reports pass/fail, error count and first failing address.
- Sits in the rocket clock domain, in place of or muxed with the core's memory master, for board bring-up and DDR calibration checks.
- One outstanding transaction at a time.

Parameters:
- BURST_LEN, 16, beats per burst (power of 2, ≤256); awlen/arlen = BURST_LEN-1.
- ID, 0, AXI ID driven on aw_id/ar_id; expected on b_id/r_id.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a test; sampled only in IDLE.
- base_addr  in  32  region base; low log2(BURST_LEN*8) bits forced to 0.
- num_bursts  in  16  bursts to write then read.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  valid after done; held until next start.
- err_count  out  16  saturating error counter.
- first_err_addr  out  32  byte address of first error.
- io_axi4_aw_valid/ready/id[3:0]/addr[31:0]/len[7:0]/size[2:0]/burst[1:0]  out/in/out…  write address channel.
- io_axi4_aw_lock/cache[3:0]/prot[2:0]/qos[3:0]  out  constants 0/4'b0011/0/0; same for ar_*.
- io_axi4_w_valid/ready/data[63:0]/strb[7:0]/last  out/in/out/out/out  write data channel.
- io_axi4_b_valid/ready/id[3:0]/resp[1:0]  in/out/in/in  write response channel.
- io_axi4_ar_valid/ready/id/addr/len/size/burst  out/in/out…  read address channel.
- io_axi4_r_valid/ready/id[3:0]/data[63:0]/resp[1:0]/last  in/out/in/in/in/in  read data channel.

Behaviour:
- Reset values: all valid/ready outputs 0; busy, done, pass, err_count, first_err_addr 0; FSM in IDLE.
- Fixed fields: size = 3'b011 (8 B), burst = 2'b01 INCR, strb = 8'hFF.
- Beat address: A = base + burst_idx*BURST_LEN*8 + beat*8, mod 2^32.
- Pattern: data(A) = {~A, A}.
- Alignment keeps each burst inside one 4 KB page.
- FSM: IDLE -> WR_AW -> WR_W -> WR_B -> (more bursts ? WR_AW : RD_AR) -> RD_R -> (more ? RD_AR : FIN) -> IDLE.
- IDLE: on start with num_bursts==0, go to FIN directly (pass=1, no AXI traffic).
- IDLE: on start otherwise, clear err_count, first_err_addr and pass; latch base and count. aw_valid rises the cycle after start.
- WR_AW: hold aw_valid with stable fields until aw_ready.
- WR_W: w_valid=1, data(A) per beat; advance on w_ready; w_last on beat BURST_LEN-1; exit after last handshake.
- WR_B: b_ready=1; on b_valid, an error is b_resp≠0 or b_id≠ID, logged at the burst start address.
- RD_AR: same as WR_AW, on the read channel.
- RD_R: r_ready=1; each beat is an error if r_resp≠0, r_id≠ID, or r_data≠data(A), logged at A.
  - r_last early or missing at beat BURST_LEN-1 is one error.
  - Leave after the r_last beat or the BURST_LEN-th beat, whichever comes first.
- FIN: done=1 for one cycle; pass = (err_count==0); busy drops the same cycle.
- Error accounting:
  - err_count saturates at 16'hFFFF.
  - first_err_addr is written only when err_count==0 before the increment.
  - Multiple error causes on one beat count once.
- Valids never deassert before their handshake; payloads stay stable while valid && !ready.
- start while busy is ignored.
- Burst counter wraps naturally in 16 bits; address arithmetic is modulo 2^32.
- Reset mid-operation: asynchronous return to IDLE with all outputs at reset values. The slave side shares this reset, so the abandoned transaction is acceptable.

Decomposition:
- Package axi_mem_tester_pkg:
  - state enum.
  - AXI constants: BURST_INCR, SIZE_8B, RESP_OKAY, CACHE_DEFAULT.
  - pattern function addr→data.
- Sub-module axi_beat_counter: beat/burst counters, address generation, last flag. It is shared by the write and read paths, since they never overlap.

Test Plan:
- Back-to-back transfers: num_bursts=2, base=0x1000, always-ready memory model.
  - Expect AW at 0x1000 and 0x1080 with len=15, then 32 W beats; first beat data 0xFFFFEFFF_00001000, beat 15 w_last=1.
  - Expect matching reads, then done pulse, pass=1, err_count=0.
- Corrupted read: same run, model flips bit 0 of read beat 5 in burst 1 -> err_count=1, first_err_addr=0x000010A8, pass=0.
- Backpressure: random ready/valid gaps (0–7 cycles) on every channel -> identical results to the first scenario; assertions hold payload stable while stalled; no valid drops before its handshake.
- Write response error: b_resp=SLVERR on burst 0 -> err_count=1, first_err_addr=0x00001000; read phase still runs.
- Empty test: num_bursts=0 -> done exactly 2 cycles after start, pass=1, no valid asserted on any channel.
- Reset recovery: reset asserted mid WR_W -> all valids 0 asynchronously, busy=0; after release, a new start with num_bursts=1 completes with pass=1.
